uart_key_decoder: RTL and testbench

Upstream input stage for the battle `Machine`. It receives 8N1 serial bytes from the board's USB-UART keyboard link, maps the game keys to the 4-bit `keyboard` command code, and drives that code to `Machine` as a one-cycle pulse. At all other times the code is `4'b0000`.

---
 rtl/uart_key_decoder.sv | 167 ++++++++++++++++
 tb/tb_uart_key_decoder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_key_decoder.sv
// 8N1 UART receiver that maps game keys to one-cycle command pulses.
// Optional KEY_HOLDOFF_EN suppresses repeats of the same key code.
module uart_key_decoder #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int HOLDOFF_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] keyboard,
  output logic       keyValid,
  output logic [7:0] rxByte,
  output logic       byteValid,
  output logic       frameErr
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(DIV - 1);

  if (DIV < 4 || HOLDOFF_CYCLES > 32'hFF_FFFF) begin : g_cfg_err
    $error("uart_key_decoder: DIV < 4 or HOLDOFF_CYCLES too large");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          meta_q, rxs_q;
  logic          tick;

  logic [3:0] key_q, key_d;
  logic       kv_q, kv_d;
  logic [7:0] byte_q, byte_d;
  logic       bv_q, bv_d;
  logic       fe_q, fe_d;
  logic       good, emit;
  logic [3:0] code;

  assign tick = (cnt_q == '0);

  function automatic logic [3:0] keymap(input logic [7:0] b);
    logic [3:0] k;
    k = 4'b0000;
    unique case (1'b1)
      b == 8'h77:              k = 4'b0001;
      b == 8'h61:              k = 4'b0010;
      b == 8'h73:              k = 4'b0011;
      b == 8'h64:              k = 4'b0100;
      b == 8'h20 || b == 8'h0D: k = 4'b1000;
      default:                 k = 4'b0000;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      meta_q  <= rx;
      rxs_q   <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = HALF_LD;
        end
      end
      START: if (tick) begin
        state_d = rxs_q ? IDLE : DATA;
        cnt_d   = BIT_LD;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        sh_d  = {rxs_q, sh_q[7:1]};
        cnt_d = BIT_LD;
        if (bit_q == 3'd7) state_d = STOP;
        else bit_d = bit_q + 3'd1;
      end
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef KEY_HOLDOFF_EN
  logic [23:0] hold_q, hold_d;
  logic [3:0]  last_q, last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      last_q <= '0;
    end else begin
      hold_q <= hold_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    emit   = good && code != 4'b0000 &&
             !(hold_q != '0 && code == last_q);
    hold_d = (hold_q != '0) ? hold_q - 24'd1 : hold_q;
    last_d = last_q;
    if (emit) begin
      hold_d = 24'(HOLDOFF_CYCLES);
      last_d = code;
    end
  end
`else
  assign emit = good && code != 4'b0000;
`endif

  always_comb begin
    good   = (state_q == STOP) && tick && rxs_q;
    code   = keymap(sh_q);
    fe_d   = (state_q == STOP) && tick && !rxs_q;
    bv_d   = good;
    byte_d = good ? sh_q : byte_q;
    kv_d   = emit;
    key_d  = emit ? code : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q  <= '0;
      kv_q   <= 1'b0;
      byte_q <= '0;
      bv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      key_q  <= key_d;
      kv_q   <= kv_d;
      byte_q <= byte_d;
      bv_q   <= bv_d;
      fe_q   <= fe_d;
    end
  end

  assign keyboard  = key_q;
  assign keyValid  = kv_q;
  assign rxByte    = byte_q;
  assign byteValid = bv_q;
  assign frameErr  = fe_q;

endmodule

// File: tb/tb_uart_key_decoder.sv
// Directed bench for uart_key_decoder with DIV = 16.
// Expected key sequences differ when KEY_HOLDOFF_EN is defined.
module tb_uart_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [3:0] keyboard;
  logic       keyValid;
  logic [7:0] rxByte;
  logic       byteValid;
  logic       frameErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] kq[$];
  int         kt[$];
  logic [7:0] bq[$];
  int         fe_n = 0;
  logic       kv_prev = 1'b0;

  uart_key_decoder #(
    .CLK_FREQ(16),
    .BAUD(1),
    .HOLDOFF_CYCLES(400)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .keyboard(keyboard),
    .keyValid(keyValid),
    .rxByte(rxByte),
    .byteValid(byteValid),
    .frameErr(frameErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse recorder plus per-pulse shape check.
  always @(negedge clk) begin
    if (keyValid || keyboard != 4'b0000) begin
      checks++;
      if (!(keyValid && keyboard != 4'b0000 && byteValid && !kv_prev)) begin
        errors++;
        $display("FAIL pulse_shape: kv=%b key=%b bv=%b prev=%b, need kv=1 key!=0 bv=1 prev=0",
                 keyValid, keyboard, byteValid, kv_prev);
      end
    end
    if (keyValid) begin
      kq.push_back(keyboard);
      kt.push_back(cyc);
    end
    if (byteValid) bq.push_back(rxByte);
    if (frameErr) fe_n++;
    kv_prev = keyValid;
  end

  task automatic clear_logs();
    kq.delete();
    kt.delete();
    bq.delete();
    fe_n = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (12) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({keyboard, keyValid, rxByte, byteValid, frameErr} !== 15'd0) begin
      errors++;
      $display("FAIL reset_in: got key=%b kv=%b byte=%h bv=%b fe=%b, need all 0",
               keyboard, keyValid, rxByte, byteValid, frameErr);
    end
    reset = 1'b0;
    idle(20);
    checks++;
    if ({keyboard, keyValid, rxByte, byteValid, frameErr} !== 15'd0) begin
      errors++;
      $display("FAIL reset_idle: got key=%b kv=%b byte=%h bv=%b fe=%b, need all 0",
               keyboard, keyValid, rxByte, byteValid, frameErr);
    end
  endtask

  task automatic test_key_d();
    int t0;
    int lat;
    clear_logs();
    t0 = cyc;
    send_frame(8'h64, 1'b1);
    idle(20);
    checks++;
    if (kq.size() != 1 || kq[0] !== 4'b0100) begin
      errors++;
      $display("FAIL d_key: got %0d pulses first=%b, need 1 pulse 0100",
               kq.size(), (kq.size() > 0) ? kq[0] : 4'hx);
    end
    checks++;
    if (bq.size() != 1 || bq[0] !== 8'h64) begin
      errors++;
      $display("FAIL d_byte: got %0d bytes first=%h, need 1 byte 64",
               bq.size(), (bq.size() > 0) ? bq[0] : 8'hxx);
    end
    lat = (kt.size() > 0) ? kt[0] - t0 : -1;
    checks++;
    if (lat < 154 || lat > 156) begin
      errors++;
      $display("FAIL d_latency: got %0d clocks, need 155 +/- 1", lat);
    end
    checks++;
    if (rxByte !== 8'h64 || keyboard !== 4'b0000 || keyValid !== 1'b0) begin
      errors++;
      $display("FAIL d_after: got byte=%h key=%b kv=%b, need 64 0000 0",
               rxByte, keyboard, keyValid);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    int nexp;
    clear_logs();
    send_frame(8'h20, 1'b1);
    send_frame(8'h0D, 1'b1);
    idle(20);
`ifdef KEY_HOLDOFF_EN
    nexp = 1;
`else
    nexp = 2;
`endif
    checks++;
    if (kq.size() != nexp || kq[0] !== 4'b1000 ||
        (nexp == 2 && kq[nexp-1] !== 4'b1000)) begin
      errors++;
      $display("FAIL b2b_keys: got %0d pulses first=%b, need %0d pulses of 1000",
               kq.size(), (kq.size() > 0) ? kq[0] : 4'hx, nexp);
    end
    checks++;
    if (bq.size() != 2 || bq[0] !== 8'h20 || bq[1] !== 8'h0D) begin
      errors++;
      $display("FAIL b2b_bytes: got %0d bytes, need 20 then 0D", bq.size());
    end
    if (nexp == 2) begin
      gap = (kt.size() >= 2) ? kt[1] - kt[0] : -1;
      checks++;
      if (gap < 158 || gap > 162) begin
        errors++;
        $display("FAIL b2b_gap: got %0d clocks, need 160 +/- 2", gap);
      end
    end
  endtask

  task automatic test_nokey();
    clear_logs();
    send_frame(8'h78, 1'b1);
    idle(20);
    checks++;
    if (bq.size() != 1 || bq[0] !== 8'h78 || rxByte !== 8'h78) begin
      errors++;
      $display("FAIL x_byte: got %0d bytes rxByte=%h, need 1 byte 78",
               bq.size(), rxByte);
    end
    checks++;
    if (kq.size() != 0) begin
      errors++;
      $display("FAIL x_nokey: got %0d key pulses, need 0", kq.size());
    end
  endtask

  task automatic test_frame_err();
    clear_logs();
    send_frame(8'h77, 1'b0);
    idle(40);
    checks++;
    if (fe_n != 1) begin
      errors++;
      $display("FAIL ferr_pulse: got %0d frameErr pulses, need 1", fe_n);
    end
    checks++;
    if (bq.size() != 0 || kq.size() != 0 || rxByte !== 8'h78) begin
      errors++;
      $display("FAIL ferr_quiet: got %0d bytes %0d keys rxByte=%h, need 0 0 78",
               bq.size(), kq.size(), rxByte);
    end
    clear_logs();
    send_frame(8'h73, 1'b1);
    idle(20);
    checks++;
    if (kq.size() != 1 || kq[0] !== 4'b0011 || fe_n != 0) begin
      errors++;
      $display("FAIL ferr_next: got %0d pulses first=%b fe=%0d, need 1 pulse 0011 fe=0",
               kq.size(), (kq.size() > 0) ? kq[0] : 4'hx, fe_n);
    end
  endtask

  task automatic test_glitch_reset();
    logic [7:0] a;
    a = 8'h61;
    clear_logs();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = a[i];
      repeat (16) @(negedge clk);
    end
    rx = a[3];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(200);
    checks++;
    if (kq.size() != 0 || bq.size() != 0 || fe_n != 0) begin
      errors++;
      $display("FAIL glitch_reset_quiet: got %0d keys %0d bytes %0d ferr, need 0 0 0",
               kq.size(), bq.size(), fe_n);
    end
    checks++;
    if (rxByte !== 8'h00) begin
      errors++;
      $display("FAIL glitch_reset_byte: got rxByte=%h, need 00", rxByte);
    end
    send_frame(8'h61, 1'b1);
    idle(20);
    checks++;
    if (kq.size() != 1 || kq[0] !== 4'b0010) begin
      errors++;
      $display("FAIL glitch_reset_next: got %0d pulses first=%b, need 1 pulse 0010",
               kq.size(), (kq.size() > 0) ? kq[0] : 4'hx);
    end
  endtask

  task automatic test_holdoff();
    logic [3:0] exp_k[$];
    bit bad;
    clear_logs();
    send_frame(8'h77, 1'b1);
    send_frame(8'h77, 1'b1);
    send_frame(8'h61, 1'b1);
    idle(20);
`ifdef KEY_HOLDOFF_EN
    exp_k = '{4'b0001, 4'b0010};
`else
    exp_k = '{4'b0001, 4'b0001, 4'b0010};
`endif
    bad = (kq.size() != exp_k.size());
    for (int i = 0; i < exp_k.size() && !bad; i++)
      if (kq[i] !== exp_k[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL holdoff_keys: got %0d pulses last=%b, need %0d pulses ending 0010",
               kq.size(), (kq.size() > 0) ? kq[kq.size()-1] : 4'hx, exp_k.size());
    end
    checks++;
    if (bq.size() != 3) begin
      errors++;
      $display("FAIL holdoff_bytes: got %0d byteValid pulses, need 3", bq.size());
    end
  endtask

  initial begin
    test_reset();
    test_key_d();
    test_back_to_back();
    test_nokey();
    test_frame_err();
    test_glitch_reset();
    test_holdoff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
